// File: rtl/eeprom_wr.sv
// eeprom_wr: I2C master doing single-byte writes and random-address reads on a 2 KB serial EEPROM.
// Optional build macro EEPROM_ACK_CHECK_EN: abort on slave NACK and report it on ack_err.
module eeprom_wr #(
  parameter int CLK_DIV = 25
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr,
  input  logic        rd,
  input  logic [10:0] addr,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        busy,
  output logic        done,
  output logic        ack_err,
  output logic        scl,
  inout  wire         sda
);

  typedef enum logic [3:0] {
    IDLE, START, TX, RXACK, RSTART, RX, MNACK, STOP, DONE
  } state_t;

  localparam int TW = $clog2(CLK_DIV);

`ifdef EEPROM_ACK_CHECK_EN
  localparam bit ACK_CHECK = 1'b1;
`else
  localparam bit ACK_CHECK = 1'b0;
`endif

  state_t          state, state_next;
  logic [TW-1:0]   tick;
  logic [1:0]      q;
  logic [2:0]      bit_cnt;
  logic [1:0]      byte_idx;
  logic            op_rd;
  logic [10:0]     addr_q;
  logic [7:0]      data_q, tx_shift, rx_shift;
  logic            nack;
  logic [1:0]      sda_sync;
  logic            sda_in, sda_low, sda_low_d, scl_d;
  logic            tick_last, phase_end, sample_pt, accept;
  logic [7:0]      cw, cr;

  assign tick_last = (tick == TW'(CLK_DIV - 1));
  assign phase_end = tick_last && (q == 2'd3);
  assign sample_pt = tick_last && (q == 2'd2);
  assign accept    = (state == IDLE) && (wr || rd);
  assign sda_in    = sda_sync[1];
  assign cw        = {4'b1010, addr_q[10:8], 1'b0};
  assign cr        = {4'b1010, addr_q[10:8], 1'b1};
  assign sda       = sda_low ? 1'b0 : 1'bz;

  // NOTE: clocked state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
  always_comb begin
    state_next = state;
    scl_d      = 1'b1;
    sda_low_d  = 1'b0;
    unique case (state)
      IDLE:   if (wr || rd) state_next = START;
      START: begin
        scl_d     = (q != 2'd3);
        sda_low_d = q[1];
        if (phase_end) state_next = TX;
      end
      TX: begin
        scl_d     = q[1];
        sda_low_d = ~tx_shift[7];
        if (phase_end && bit_cnt == 3'd7) state_next = RXACK;
      end
      RXACK: begin
        scl_d = q[1];
        if (phase_end) begin
          if (ACK_CHECK && nack)   state_next = STOP;
          else if (byte_idx == 2'd0) state_next = TX;
          else if (byte_idx == 2'd1) state_next = op_rd ? RSTART : TX;
          else                       state_next = op_rd ? RX : STOP;
        end
      end
      RSTART: begin
        // Release SDA while SCL is low so the repeated START edge happens with SCL high.
        scl_d     = (q == 2'd1) || (q == 2'd2);
        sda_low_d = q[1];
        if (phase_end) state_next = TX;
      end
      RX: begin
        scl_d = q[1];
        if (phase_end && bit_cnt == 3'd7) state_next = MNACK;
      end
      MNACK: begin
        scl_d = q[1];
        if (phase_end) state_next = STOP;
      end
      STOP: begin
        scl_d     = (q != 2'd0);
        sda_low_d = ~q[1];
        if (phase_end) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick <= '0;
      q    <= 2'd0;
    end else if (state == IDLE || state == DONE) begin
      tick <= '0;
      q    <= 2'd0;
    end else begin
      tick <= tick_last ? '0 : tick + 1'b1;
      if (tick_last) q <= q + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_rd    <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      bit_cnt  <= '0;
      byte_idx <= '0;
      nack     <= 1'b0;
    end else begin
      if (accept) begin
        op_rd  <= ~wr;
        addr_q <= addr;
        data_q <= data_in;
        nack   <= 1'b0;
      end
      case (state)
        START: if (phase_end) begin
          tx_shift <= cw;
          bit_cnt  <= '0;
          byte_idx <= 2'd0;
        end
        TX: if (phase_end) begin
          bit_cnt  <= bit_cnt + 3'd1;
          tx_shift <= {tx_shift[6:0], 1'b0};
        end
        RXACK: begin
          if (sample_pt) nack <= sda_in;
          if (phase_end) begin
            if (byte_idx == 2'd0) begin
              tx_shift <= addr_q[7:0];
              byte_idx <= 2'd1;
            end else if (byte_idx == 2'd1 && !op_rd) begin
              tx_shift <= data_q;
              byte_idx <= 2'd2;
            end
          end
        end
        RSTART: if (phase_end) begin
          tx_shift <= cr;
          byte_idx <= 2'd2;
        end
        RX: begin
          if (sample_pt) rx_shift <= {rx_shift[6:0], sda_in};
          if (phase_end) bit_cnt <= bit_cnt + 3'd1;
        end
        default: ;
      endcase
    end
  end

  // Bus pins and status are registered, so they trail the state by one clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl      <= 1'b1;
      sda_low  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      data_out <= 8'h00;
      sda_sync <= 2'b11;
    end else begin
      scl      <= scl_d;
      sda_low  <= sda_low_d;
      busy     <= (state != IDLE);
      done     <= (state == DONE);
      sda_sync <= {sda_sync[0], sda};
      if (state == DONE && op_rd && !(ACK_CHECK && nack)) data_out <= rx_shift;
    end
  end

`ifdef EEPROM_ACK_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      ack_err <= 1'b0;
    else if (accept)                ack_err <= 1'b0;
    else if (state == DONE && nack) ack_err <= 1'b1;
  end
`else
  assign ack_err = 1'b0;
`endif

endmodule

// File: tb/tb_eeprom_wr.sv
// tb_eeprom_wr: drives eeprom_wr against a behavioural I2C EEPROM on a pulled-up bus.
// Expected bus bytes, latencies and read data come from the bench's own reference memory.
`timescale 1ns/1ps
module tb_eeprom_wr;
  localparam int D        = 4;
  localparam int WR_LAT   = 1 + 116 * D;
  localparam int RD_LAT   = 1 + 156 * D;
  localparam int NACK_LAT = 1 + 80 * D;

  logic        clk = 1'b0, reset = 1'b1, wr = 1'b0, rd = 1'b0;
  logic [10:0] addr = '0;
  logic [7:0]  data_in = '0;
  logic [7:0]  data_out;
  logic        busy, done, ack_err, scl;
  wire         sda;
  logic        slave_low = 1'b0;

  pullup (sda);
  assign sda = slave_low ? 1'b0 : 1'bz;

  eeprom_wr #(.CLK_DIV(D)) dut (
    .clk(clk), .reset(reset), .wr(wr), .rd(rd), .addr(addr), .data_in(data_in),
    .data_out(data_out), .busy(busy), .done(done), .ack_err(ack_err),
    .scl(scl), .sda(sda)
  );

  always #5 clk = ~clk;

  int          total = 0, bad = 0;
  logic [7:0]  mem     [0:2047];
  logic [7:0]  ref_mem [0:2047];
  logic [7:0]  bus_log [0:255];
  int          bus_n = 0, start_n = 0, stop_n = 0;
  logic        last_mack = 1'b0;
  int          nack_byte = -1;
  logic [7:0]  exp_dout = 8'h00;

  // Behavioural EEPROM slave: watches the bus mid-cycle and answers like the real device.
  initial begin : slave
    logic ps, pd, cs, cd, reading, pend_rd, ignore;
    logic [7:0] sh, txb;
    logic [10:0] ptr;
    int bitn, byte_no;
    for (int i = 0; i < 2048; i++) mem[i] = 8'hFF;
    ps = 1; pd = 1; reading = 0; pend_rd = 0; ignore = 0;
    sh = 0; txb = 0; ptr = 0; bitn = 0; byte_no = 0;
    forever begin
      @(negedge clk);
      cs = scl; cd = sda;
      if (ps && cs && pd && !cd) begin
        start_n++; bitn = 0; byte_no = 0; reading = 0; pend_rd = 0; ignore = 0; slave_low = 0;
      end else if (ps && cs && !pd && cd) begin
        stop_n++; bitn = 0; reading = 0; slave_low = 0;
      end else if (!ps && cs) begin
        if (bitn < 8 && !reading) sh = {sh[6:0], cd};
        if (bitn == 8 && reading) last_mack = cd;
        bitn++;
      end else if (ps && !cs) begin
        if (bitn == 8 && !reading) begin
          bus_log[8'(bus_n)] = sh;
          bus_n++;
          if (byte_no == nack_byte) ignore = 1;
          if (!ignore) begin
            case (byte_no)
              0:       begin ptr[10:8] = sh[3:1]; pend_rd = sh[0]; end
              1:       ptr[7:0] = sh;
              default: mem[ptr] = sh;
            endcase
          end
          byte_no++;
          slave_low = !ignore;
        end else if (bitn == 8) begin
          slave_low = 0;
        end else if (bitn == 9) begin
          bitn = 0; slave_low = 0; reading = 0;
          if (pend_rd && !ignore) begin
            reading = 1; pend_rd = 0; txb = mem[ptr]; slave_low = !txb[7];
          end
        end else if (reading && bitn >= 1) begin
          slave_low = !txb[3'(7 - bitn)];
        end
      end
      ps = cs; pd = cd;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One request: waits (bounded) for done, then checks timing, bus traffic and results.
  task automatic run(input logic w, input logic r, input logic [10:0] a, input logic [7:0] d,
                     input int poke_at, input string tag);
    int k, base, s0, p0, exp_lat, n_exp, st_exp;
    logic seen, busy_ok, nacked, exp_err;
    logic [7:0] e [3];
    nacked = w && (nack_byte == 1);
`ifdef EEPROM_ACK_CHECK_EN
    exp_err = nacked;
`else
    exp_err = 1'b0;
`endif
    exp_lat = exp_err ? NACK_LAT : (w ? WR_LAT : RD_LAT);
    n_exp   = exp_err ? 2 : 3;
    st_exp  = w ? 1 : 2;
    e[0] = {4'b1010, a[10:8], 1'b0};
    e[1] = a[7:0];
    e[2] = w ? d : {4'b1010, a[10:8], 1'b1};
    base = bus_n; s0 = start_n; p0 = stop_n;

    @(negedge clk);
    wr = w; rd = r; addr = a; data_in = d;
    @(posedge clk);
    #1;
    wr = 0; rd = 0; addr = 11'($urandom); data_in = 8'($urandom);
    k = 0; seen = 0; busy_ok = 1;
    while (!seen && k < exp_lat + 50) begin
      @(posedge clk);
      k++;
      #1;
      if (!busy) busy_ok = 0;
      rd = (k == poke_at);
      if (done) seen = 1;
    end
    rd = 0;

    if (w && !nacked) ref_mem[a] = d;
    if (!w) exp_dout = ref_mem[a];
    check({tag, "/latency"}, k, exp_lat);
    check({tag, "/busy_held"}, busy_ok, 1);
    check({tag, "/data_out"}, data_out, exp_dout);
    check({tag, "/ack_err"}, ack_err, exp_err);
    check({tag, "/nbytes"}, bus_n - base, n_exp);
    for (int i = 0; i < n_exp; i++) check({tag, "/byte"}, bus_log[8'(base + i)], e[i]);
    check({tag, "/starts"}, start_n - s0, st_exp);
    check({tag, "/stops"}, stop_n - p0, 1);
    if (!w) check({tag, "/master_nack"}, last_mack, 1);
    check({tag, "/eeprom_mem"}, mem[a], ref_mem[a]);
    @(posedge clk);
    #1;
    check({tag, "/done_pulse"}, done, 0);
    check({tag, "/busy_clear"}, busy, 0);
    check({tag, "/ack_err_hold"}, ack_err, exp_err);
  endtask

  initial begin : stim
    logic [10:0] a;
    logic [7:0]  d;
    int s0, dn;
    for (int i = 0; i < 2048; i++) ref_mem[i] = 8'hFF;

    repeat (3) @(posedge clk);
    #1;
    check("rst/scl", scl, 1);
    check("rst/sda", sda, 1);
    check("rst/busy", busy, 0);
    check("rst/done", done, 0);
    check("rst/ack_err", ack_err, 0);
    check("rst/data_out", data_out, 8'h00);
    @(negedge clk) reset = 0;
    repeat (4) @(posedge clk);

    run(1, 0, 11'h3C7, 8'hA5, -1, "wr_3c7");
    run(0, 1, 11'h3C7, 8'h00, -1, "rd_3c7");

    // Simultaneous wr and rd: the write must win and only one transaction occur.
    run(1, 1, 11'h001, 8'h5A, -1, "wr_rd_same");
    s0 = start_n;
    repeat (40) @(posedge clk);
    #1;
    check("wr_rd_same/no_extra_start", start_n - s0, 0);
    check("wr_rd_same/idle", busy, 0);

    // Read request while busy is ignored.
    run(1, 0, 11'h7FE, 8'h3C, 100, "rd_while_busy");
    s0 = start_n; dn = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) dn++;
    end
    check("rd_while_busy/no_extra_start", start_n - s0, 0);
    check("rd_while_busy/no_extra_done", dn, 0);
    run(0, 1, 11'h001, 8'h00, -1, "rd_001");

    for (int n = 0; n < 4; n++) begin
      a = 11'($urandom);
      d = 8'($urandom);
      run(1, 0, a, d, -1, "rand_wr");
      run(0, 1, a, 8'h00, -1, "rand_rd");
    end
    a = 11'($urandom_range(1024, 2047));
    if (a == 11'h7FE || a == 11'h3C7) a = 11'h555;
    run(0, 1, a, 8'h00, -1, "rd_unwritten");

    // Asynchronous reset in the middle of a write.
    @(negedge clk);
    wr = 1; addr = 11'h2AA; data_in = 8'hEE;
    @(posedge clk);
    #1;
    wr = 0;
    repeat (49) @(posedge clk);
    #1;
    reset = 1;
    #1;
    check("mid_rst/scl", scl, 1);
    check("mid_rst/sda", sda, 1);
    check("mid_rst/busy", busy, 0);
    check("mid_rst/done", done, 0);
    check("mid_rst/data_out", data_out, 8'h00);
    exp_dout = 8'h00;
    @(negedge clk) reset = 0;
    repeat (4) @(posedge clk);
    check("mid_rst/eeprom_untouched", mem[11'h2AA], ref_mem[11'h2AA]);
    run(1, 0, 11'h010, 8'h11, -1, "post_rst_wr");
    run(0, 1, 11'h010, 8'h00, -1, "post_rst_rd");

    // Slave refuses the address byte.
    nack_byte = 1;
    run(1, 0, 11'h123, 8'h77, -1, "addr_nack");
    repeat (10) @(posedge clk);
    nack_byte = -1;
    run(1, 0, 11'h124, 8'h78, -1, "after_nack_wr");
    run(0, 1, 11'h123, 8'h00, -1, "after_nack_rd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
